// File: rtl/div_iter_hs.sv
// Iterative radix-2 restoring divider with valid/ready handshakes.
// Signed/unsigned per request, div-by-zero and overflow flags, tag passthrough.
module div_iter_hs #(
   parameter int DIVIDEND_WIDTH = 64,
   parameter int DIVISOR_WIDTH  = 32,
   parameter int TAG_WIDTH      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_signed,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   input  logic [TAG_WIDTH-1:0]      in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero,
   output logic                      overflow,
   output logic [TAG_WIDTH-1:0]      out_tag
);

   localparam int W  = DIVIDEND_WIDTH;
   localparam int D  = DIVISOR_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP,
      DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [D-1:0]   rem_q, rem_d;
   logic [D-1:0]   dsor_q, dsor_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [W-1:0]   resq_q, resq_d;
   logic [D-1:0]   resr_q, resr_d;
   logic           dbz_q, dbz_d;
   logic           ovf_q, ovf_d;
   logic [TAG_WIDTH-1:0] otag_q, otag_d;

   logic           dvd_neg;
   logic           dsr_neg;
   logic [D:0]     rem_shift;
   logic           ge;

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = resq_q;
   assign remainder   = resr_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
   assign out_tag     = otag_q;

   assign dvd_neg = in_signed & dividend[W-1];
   assign dsr_neg = in_signed & divisor[D-1];

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   always_comb begin
      rem_shift = {rem_q, quo_q[W-1]};
      ge        = (rem_shift >= {1'b0, dsor_q});
   end

   // Next-state and datapath for accept, iterate, sign fixup and hold.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dsor_d  = dsor_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      tag_d   = tag_q;
      resq_d  = resq_q;
      resr_d  = resr_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      otag_d  = otag_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // W-bit magnitude suffices: |MIN| = 2^(W-1) fits unsigned.
               quo_d  = dvd_neg ? -dividend : dividend;
               dsor_d = dsr_neg ? -divisor : divisor;
               rem_d  = '0;
               qneg_d = dvd_neg ^ dsr_neg;
               rneg_d = dvd_neg;
               tag_d  = in_tag;
               cnt_d  = CW'(W - 1);
               if (divisor == '0) begin
                  resq_d  = '1;
                  resr_d  = dividend[D-1:0];
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
                  otag_d  = in_tag;
                  state_d = DONE;
               end else if (in_signed && dividend == MIN && (&divisor)) begin
                  resq_d  = MIN;
                  resr_d  = '0;
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b1;
                  otag_d  = in_tag;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = D'(ge ? rem_shift - {1'b0, dsor_q} : rem_shift);
            quo_d = {quo_q[W-2:0], ge};
            if (cnt_q == '0) begin
               state_d = FIXUP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIXUP: begin
            resq_d  = qneg_q ? -quo_q : quo_q;
            resr_d  = rneg_q ? -rem_q : rem_q;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            otag_d  = tag_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dsor_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         tag_q   <= '0;
         resq_q  <= '0;
         resr_q  <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         otag_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dsor_q  <= dsor_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         tag_q   <= tag_d;
         resq_q  <= resq_d;
         resr_q  <= resr_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         otag_q  <= otag_d;
      end
   end

endmodule

// File: tb/tb_div_iter_hs.sv
// Directed table-driven bench for div_iter_hs at default widths.
// Checks results, flags, tags, latency, backpressure and mid-op reset.
module tb_div_iter_hs;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_signed;
   logic [63:0] dividend;
   logic [31:0] divisor;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
   logic        overflow;
   logic [3:0]  out_tag;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        sgn;
      logic [63:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [63:0] eq;
      logic [31:0] er;
      logic        dbz;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vt[13];

   div_iter_hs dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_signed   (in_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic sgn, input logic [63:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
      in_valid  = 1'b1;
      in_signed = sgn;
      dividend  = a;
      divisor   = b;
      in_tag    = tag;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_signed = ~sgn;
      dividend  = ~a;
      divisor   = ~b;
      in_tag    = ~tag;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
   endtask

   task automatic run(input vec_t v, input int idx);
      int lat;
      send(v.sgn, v.a, v.b, v.tag);
      wait_valid(lat);
      chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
      chk($sformatf("v%0d quotient", idx), quotient, v.eq);
      chk($sformatf("v%0d remainder", idx), 64'(remainder), 64'(v.er));
      chk($sformatf("v%0d div_by_zero", idx), 64'(div_by_zero), 64'(v.dbz));
      chk($sformatf("v%0d overflow", idx), 64'(overflow), 64'(v.ovf));
      chk($sformatf("v%0d out_tag", idx), 64'(out_tag), 64'(v.tag));
      chk($sformatf("v%0d in_ready_done", idx), 64'(in_ready), 0);
      drain();
   endtask

   initial begin
      int  lat;
      logic ok;
      vec_t v;

      vt[0]  = '{1'b1, -64'd100, 32'd7, 4'd3, -64'd14, -32'd2, 1'b0, 1'b0, 66};
      vt[1]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 4'd1,
                 64'h1_0000_0001, 32'd0, 1'b0, 1'b0, 66};
      vt[2]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 4'd2,
                 64'd1, 32'd0, 1'b0, 1'b0, 66};
      vt[3]  = '{1'b0, 64'd1234, 32'd0, 4'd4,
                 64'hFFFF_FFFF_FFFF_FFFF, 32'd1234, 1'b1, 1'b0, 1};
      vt[4]  = '{1'b1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 4'd5,
                 64'h8000_0000_0000_0000, 32'd0, 1'b0, 1'b1, 1};
      vt[5]  = '{1'b1, 64'd100, -32'd7, 4'd6, -64'd14, 32'd2, 1'b0, 1'b0, 66};
      vt[6]  = '{1'b0, 64'd100, 32'd7, 4'd7, 64'd14, 32'd2, 1'b0, 1'b0, 66};
      vt[7]  = '{1'b0, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 4'd8,
                 64'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 66};
      vt[8]  = '{1'b1, -64'd7, 32'd0, 4'd9,
                 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0, 1};
      vt[9]  = '{1'b1, -64'd1, 32'd2, 4'd10, 64'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 66};
      vt[10] = '{1'b1, 64'h8000_0000_0000_0000, 32'd1, 4'd11,
                 64'h8000_0000_0000_0000, 32'd0, 1'b0, 1'b0, 66};
      vt[11] = '{1'b1, 64'h8000_0000_0000_0000, 32'd2, 4'd12,
                 64'hC000_0000_0000_0000, 32'd0, 1'b0, 1'b0, 66};
      vt[12] = '{1'b0, 64'd5, 32'd10, 4'd13, 64'd0, 32'd5, 1'b0, 1'b0, 66};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst quotient", quotient, 0);
      chk("rst remainder", 64'(remainder), 0);
      chk("rst flags", 64'({div_by_zero, overflow}), 0);
      chk("rst out_tag", 64'(out_tag), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst in_ready", in_ready, 1);

      for (int i = 0; i < 13; i++) begin
         run(vt[i], i);
      end

      // Backpressure: results must hold while out_ready is low.
      send(1'b0, 64'd1000, 32'd3, 4'd5);
      wait_valid(lat);
      chk("bp latency", 64'(lat), 66);
      for (int i = 0; i < 10; i++) begin
         ok = out_valid && !in_ready && quotient == 64'd333 &&
              remainder == 32'd1 && out_tag == 4'd5 &&
              !div_by_zero && !overflow;
         chk($sformatf("bp hold %0d", i), 64'(ok), 1);
         @(negedge clk);
      end
      drain();

      // Reset mid-calculation: outputs clear at once, next op is clean.
      send(1'b0, 64'd1000, 32'd3, 4'd6);
      repeat (20) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst quotient", quotient, 0);
      chk("mid rst remainder", 64'(remainder), 0);
      chk("mid rst flags", 64'({div_by_zero, overflow}), 0);
      chk("mid rst out_tag", 64'(out_tag), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post rst in_ready", in_ready, 1);
      v = '{1'b1, 64'd50, -32'd5, 4'd14, -64'd10, 32'd0, 1'b0, 1'b0, 66};
      run(v, 13);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
